sudoku_link_ctrl: RTL and testbench

- Parametrised multi-board link controller for the handwritten-Sudoku game.
- Generalises the current two-board connect/start/finish handshake to NUM_PEERS remote boards.
- Adds input synchronisation, a connect timeout, link-loss detection and winner identification.
- Sits between the stage/menu logic (mouse button pulses, solver valid flag) and the inter-board wires.

---
 rtl/sudoku_link_pkg.sv | 25 ++
 rtl/sudoku_link_sync.sv | 40 ++++
 rtl/sudoku_link_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_sudoku_link_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_link_pkg.sv
// -----------------------------------------------------------------------------
// sudoku_link_pkg
// Shared definitions for the multi-board Sudoku link controller.
//   STATE_W       width of the exported FSM state code
//   link_state_e  state codes IDLE..DONE (codes 5-7 are illegal)
//   winner_width  width of the winner field for a given peer count
// -----------------------------------------------------------------------------
package sudoku_link_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_CONNECT = 3'd1,
        ST_READY   = 3'd2,
        ST_GAME    = 3'd3,
        ST_DONE    = 3'd4
    } link_state_e;

    // Winner encodes 0 for the local board and i+1 for peer i.
    function automatic int winner_width(input int num_peers);
        return (num_peers < 1) ? 1 : $clog2(num_peers + 1);
    endfunction

endpackage

// File: rtl/sudoku_link_sync.sv
// -----------------------------------------------------------------------------
// sudoku_link_sync
// WIDTH-bit multi-flop synchroniser for asynchronous inter-board lines.
// Depth is STAGES, forced to at least 2.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset, clears every stage to 0
//   din    in   WIDTH  raw asynchronous inputs
//   dout   out  WIDTH  synchronised outputs (last stage)
// -----------------------------------------------------------------------------
module sudoku_link_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/sudoku_link_ctrl.sv
// -----------------------------------------------------------------------------
// sudoku_link_ctrl
// Connect/start/finish handshake between this board and NUM_PEERS remote
// boards, with input synchronisation, link-loss detection, winner
// identification and an optional CONNECT timeout.
//
// Optional feature: define SUDOKU_LINK_TIMEOUT_EN to build the CONNECT
// timeout counter. Without it CONNECT waits indefinitely and link_lost is
// only set by a connect loss in READY/GAME.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   connect_req      one-cycle pulse, connect button
//   start_req        one-cycle pulse, start button
//   return_req       one-cycle pulse, return button
//   local_finish     level, local puzzle solved
//   rx_connect/start/finish  [NUM_PEERS] raw lines from the peers
//   tx_connect/start/finish  lines driven to all peers
//   game_init        one-cycle pulse on entry to GAME
//   state            current FSM state code
//   connected_mask   synchronised rx_connect
//   winner           0 = local board, i+1 = peer i
//   link_lost        sticky: link dropped or CONNECT timed out
//
// Handshake: pulse inputs act only in the state that consumes them on the
// cycle they are high; they are never queued. All outputs are registered and
// change on the same edge as the state they belong to.
// -----------------------------------------------------------------------------
module sudoku_link_ctrl
    import sudoku_link_pkg::*;
#(
    parameter int NUM_PEERS      = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 connect_req,
    input  logic                                 start_req,
    input  logic                                 return_req,
    input  logic                                 local_finish,
    input  logic [NUM_PEERS-1:0]                 rx_connect,
    input  logic [NUM_PEERS-1:0]                 rx_start,
    input  logic [NUM_PEERS-1:0]                 rx_finish,
    output logic                                 tx_connect,
    output logic                                 tx_start,
    output logic                                 tx_finish,
    output logic                                 game_init,
    output logic [STATE_W-1:0]                   state,
    output logic [NUM_PEERS-1:0]                 connected_mask,
    output logic [winner_width(NUM_PEERS)-1:0]   winner,
    output logic                                 link_lost
);

    localparam int WINNER_W = winner_width(NUM_PEERS);

    // ---------------------------------------------------------------------
    // Input synchronisation: one synchroniser on the packed rx bus
    // ---------------------------------------------------------------------
    logic [3*NUM_PEERS-1:0] rx_raw;
    logic [3*NUM_PEERS-1:0] rx_sync;
    logic [NUM_PEERS-1:0]   connect_sync;
    logic [NUM_PEERS-1:0]   start_sync;
    logic [NUM_PEERS-1:0]   finish_sync;

    assign rx_raw = {rx_finish, rx_start, rx_connect};

    sudoku_link_sync #(
        .WIDTH  (3*NUM_PEERS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (rx_raw),
        .dout  (rx_sync)
    );

    assign connect_sync = rx_sync[NUM_PEERS-1:0];
    assign start_sync   = rx_sync[2*NUM_PEERS-1:NUM_PEERS];
    assign finish_sync  = rx_sync[3*NUM_PEERS-1:2*NUM_PEERS];

    logic all_connected;
    assign all_connected = &connect_sync;

    // Lowest-index finishing peer wins among simultaneous remote finishes;
    // scanning downwards lets the lowest index overwrite the others.
    logic [WINNER_W-1:0] remote_winner;
    always_comb begin
        remote_winner = '0;
        for (int i = NUM_PEERS - 1; i >= 0; i--) begin
            if (finish_sync[i]) begin
                remote_winner = WINNER_W'(i + 1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // State and registered outputs
    // ---------------------------------------------------------------------
    link_state_e         state_q, state_n;
    logic                tx_connect_q, tx_connect_n;
    logic                tx_start_q,   tx_start_n;
    logic                tx_finish_q,  tx_finish_n;
    logic                game_init_q,  game_init_n;
    logic [WINNER_W-1:0] winner_q,     winner_n;
    logic                link_lost_q,  link_lost_n;
    logic                timeout_hit;

    // ---------------------------------------------------------------------
    // CONNECT timeout counter
    // ---------------------------------------------------------------------
`ifdef SUDOKU_LINK_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] timeout_cnt_q;

    // Counts cycles spent in CONNECT; held at zero elsewhere so every entry
    // starts a fresh window. Saturates at CNT_LAST instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_cnt_q <= '0;
        end else if (state_q != ST_CONNECT) begin
            timeout_cnt_q <= '0;
        end else if (timeout_cnt_q != CNT_LAST) begin
            timeout_cnt_q <= timeout_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (timeout_cnt_q == CNT_LAST);
`else
    // No counter in this build; the comparison keeps TIMEOUT_CYCLES referenced
    // so the parameter list is identical in both builds. It is constant 0.
    assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // State register and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tx_connect_q <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_finish_q  <= 1'b0;
            game_init_q  <= 1'b0;
            winner_q     <= '0;
            link_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_n;
            tx_connect_q <= tx_connect_n;
            tx_start_q   <= tx_start_n;
            tx_finish_q  <= tx_finish_n;
            game_init_q  <= game_init_n;
            winner_q     <= winner_n;
            link_lost_q  <= link_lost_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: begin
                if (connect_req) state_n = ST_CONNECT;
            end
            ST_CONNECT: begin
                if (return_req)         state_n = ST_IDLE;
                else if (all_connected) state_n = ST_READY;
                else if (timeout_hit)   state_n = ST_IDLE;
            end
            ST_READY: begin
                if (!all_connected)                 state_n = ST_IDLE;
                else if (start_req || |start_sync)  state_n = ST_GAME;
                else if (return_req)                state_n = ST_IDLE;
            end
            ST_GAME: begin
                if (local_finish || |finish_sync || !all_connected) state_n = ST_DONE;
                else if (return_req)                                state_n = ST_IDLE;
            end
            ST_DONE: begin
                if (return_req) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        tx_connect_n = (state_n != ST_IDLE);
        tx_start_n   = (state_n == ST_GAME) || (state_n == ST_DONE);
        game_init_n  = (state_q == ST_READY) && (state_n == ST_GAME);
        tx_finish_n  = 1'b0;
        winner_n     = '0;
        link_lost_n  = link_lost_q;
        case (state_q)
            ST_IDLE: begin
                if (connect_req) link_lost_n = 1'b0;
            end
            ST_CONNECT: begin
                if (!return_req && !all_connected && timeout_hit) link_lost_n = 1'b1;
            end
            ST_READY: begin
                if (!all_connected) link_lost_n = 1'b1;
            end
            ST_GAME: begin
                // Local finish beats a same-cycle remote finish.
                if (local_finish)        tx_finish_n = 1'b1;
                else if (|finish_sync)   winner_n    = remote_winner;
                else if (!all_connected) link_lost_n = 1'b1;
            end
            ST_DONE: begin
                // Hold the result until return; IDLE entry clears it.
                if (!return_req) begin
                    tx_finish_n = tx_finish_q;
                    winner_n    = winner_q;
                end
            end
            default: ;
        endcase
    end

    assign state          = state_q;
    assign tx_connect     = tx_connect_q;
    assign tx_start       = tx_start_q;
    assign tx_finish      = tx_finish_q;
    assign game_init      = game_init_q;
    assign winner         = winner_q;
    assign link_lost      = link_lost_q;
    assign connected_mask = connect_sync;

endmodule

// File: tb/tb_sudoku_link_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sudoku_link_ctrl
// Directed scenarios followed by randomized traffic; every cycle the DUT
// outputs are compared with a behavioural model of the link rules.
// -----------------------------------------------------------------------------
module tb_sudoku_link_ctrl;

    localparam int NP    = 2;
    localparam int SS    = 2;
    localparam int TO    = 100;
    localparam int VEC_W = 12;

`ifdef SUDOKU_LINK_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int M_IDLE    = 0;
    localparam int M_CONNECT = 1;
    localparam int M_READY   = 2;
    localparam int M_GAME    = 3;
    localparam int M_DONE    = 4;

    logic          clk;
    logic          reset;
    logic          connect_req, start_req, return_req, local_finish;
    logic [NP-1:0] rx_connect, rx_start, rx_finish;
    logic          tx_connect, tx_start, tx_finish, game_init, link_lost;
    logic [2:0]    state;
    logic [NP-1:0] connected_mask;
    logic [1:0]    winner;

    sudoku_link_ctrl #(
        .NUM_PEERS      (NP),
        .SYNC_STAGES    (SS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .connect_req    (connect_req),
        .start_req      (start_req),
        .return_req     (return_req),
        .local_finish   (local_finish),
        .rx_connect     (rx_connect),
        .rx_start       (rx_start),
        .rx_finish      (rx_finish),
        .tx_connect     (tx_connect),
        .tx_start       (tx_start),
        .tx_finish      (tx_finish),
        .game_init      (game_init),
        .state          (state),
        .connected_mask (connected_mask),
        .winner         (winner),
        .link_lost      (link_lost)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [VEC_W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_state, m_cnt, m_win;
    bit m_lost, m_txf, m_ginit;
    logic [3*NP-1:0] m_pipe[$];   // index 0 newest sample, back = what the FSM sees

    task automatic model_reset();
        m_state = M_IDLE; m_cnt = 0; m_win = 0;
        m_lost = 0; m_txf = 0; m_ginit = 0;
        m_pipe.delete();
        for (int i = 0; i < SS; i++) m_pipe.push_back('0);
    endtask

    function automatic int first_finisher(input logic [NP-1:0] f);
        for (int i = 0; i < NP; i++) if (f[i]) return i + 1;
        return 0;
    endfunction

    task automatic model_step();
        logic [3*NP-1:0] view;
        logic [NP-1:0]   vc, vs, vf;
        bit              all_conn;
        if (reset) begin
            model_reset();
            return;
        end
        view = m_pipe[$];
        m_pipe.push_front({rx_finish, rx_start, rx_connect});
        void'(m_pipe.pop_back());
        vc = view[NP-1:0];
        vs = view[2*NP-1:NP];
        vf = view[3*NP-1:2*NP];
        all_conn = (vc == {NP{1'b1}});
        m_ginit = 0;
        case (m_state)
            M_IDLE: if (connect_req) begin m_state = M_CONNECT; m_lost = 0; m_cnt = 0; end
            M_CONNECT: begin
                if (return_req) m_state = M_IDLE;
                else if (all_conn) m_state = M_READY;
                else if (TIMEOUT_EN && m_cnt == TO - 1) begin m_state = M_IDLE; m_lost = 1; end
                else m_cnt++;
            end
            M_READY: begin
                if (!all_conn) begin m_state = M_IDLE; m_lost = 1; end
                else if (start_req || vs != 0) begin m_state = M_GAME; m_ginit = 1; end
                else if (return_req) m_state = M_IDLE;
            end
            M_GAME: begin
                if (local_finish) begin m_state = M_DONE; m_win = 0; m_txf = 1; end
                else if (vf != 0) begin m_state = M_DONE; m_win = first_finisher(vf); m_txf = 0; end
                else if (!all_conn) begin m_state = M_DONE; m_lost = 1; m_win = 0; m_txf = 0; end
                else if (return_req) m_state = M_IDLE;
            end
            M_DONE: if (return_req) begin m_state = M_IDLE; m_win = 0; m_txf = 0; end
            default: m_state = M_IDLE;
        endcase
    endtask

    function automatic logic [VEC_W-1:0] model_vec();
        logic [3*NP-1:0] seen;
        bit in_done;
        seen = m_pipe[$];
        in_done = (m_state == M_DONE);
        return {3'(m_state), m_state != M_IDLE, m_state >= M_GAME, m_txf && in_done,
                m_ginit, seen[NP-1:0], in_done ? 2'(m_win) : 2'b00, m_lost};
    endfunction

    function automatic logic [VEC_W-1:0] dut_vec();
        return {state, tx_connect, tx_start, tx_finish, game_init,
                connected_mask, winner, link_lost};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        model_step();
        exp_q.push_back(model_vec());
        #1;
        check_eq("cycle", 32'(dut_vec()), 32'(exp_q.pop_front()));
    endtask

    task automatic pulse_connect();
        connect_req = 1'b1; cycle(); connect_req = 1'b0;
    endtask

    task automatic pulse_start();
        start_req = 1'b1; cycle(); start_req = 1'b0;
    endtask

    task automatic pulse_return();
        return_req = 1'b1; cycle(); return_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        connect_req = 0; start_req = 0; return_req = 0; local_finish = 0;
        rx_connect = '0; rx_start = '0; rx_finish = '0;
        model_reset();
        #1;
        check_eq("reset_outputs", 32'(dut_vec()), 32'd0);
        cycle(); cycle();
        reset = 1'b0;

        // Connect: tx_connect follows the request, READY 3 cycles after rx rises
        pulse_connect();
        check_eq("connect_tx", 32'(tx_connect), 32'd1);
        repeat (4) cycle();
        rx_connect = 2'b11;
        cycle(); cycle();
        check_eq("connect_not_yet", 32'(state), 32'd1);
        cycle();
        check_eq("connect_ready", 32'(state), 32'd2);

        // Remote start
        rx_start = 2'b10;
        cycle(); cycle();
        check_eq("rstart_wait", 32'(state), 32'd2);
        cycle();
        rx_start = 2'b00;
        check_eq("rstart_state", 32'(state), 32'd3);
        check_eq("rstart_tx", 32'(tx_start), 32'd1);
        check_eq("rstart_init", 32'(game_init), 32'd1);
        cycle();
        check_eq("rstart_init_once", 32'(game_init), 32'd0);

        // Remote winner is peer 1
        rx_finish = 2'b10;
        repeat (3) cycle();
        rx_finish = 2'b00;
        check_eq("rwin_state", 32'(state), 32'd4);
        check_eq("rwin_winner", 32'(winner), 32'd2);
        check_eq("rwin_txf", 32'(tx_finish), 32'd0);
        repeat (3) cycle();
        check_eq("rwin_hold", 32'(winner), 32'd2);
        pulse_return();
        check_eq("rwin_ret_state", 32'(state), 32'd0);
        check_eq("rwin_ret_winner", 32'(winner), 32'd0);

        // Same-cycle local and remote finish: local wins
        pulse_connect();
        cycle();
        check_eq("tie_ready", 32'(state), 32'd2);
        pulse_start();
        check_eq("tie_game", 32'(state), 32'd3);
        rx_finish = 2'b01;
        cycle(); cycle();
        local_finish = 1'b1;
        cycle();
        local_finish = 1'b0;
        rx_finish = 2'b00;
        check_eq("tie_state", 32'(state), 32'd4);
        check_eq("tie_winner", 32'(winner), 32'd0);
        check_eq("tie_txf", 32'(tx_finish), 32'd1);
        repeat (3) cycle();
        pulse_return();

        // Link loss in GAME, then return
        pulse_connect();
        cycle();
        pulse_start();
        rx_connect = 2'b01;
        repeat (3) cycle();
        check_eq("loss_state", 32'(state), 32'd4);
        check_eq("loss_flag", 32'(link_lost), 32'd1);
        pulse_return();
        check_eq("loss_ret_state", 32'(state), 32'd0);
        check_eq("loss_ret_tx", 32'({tx_connect, tx_start, tx_finish}), 32'd0);
        check_eq("loss_ret_winner", 32'(winner), 32'd0);

        // CONNECT timeout with only peer 0 present
        pulse_connect();
        check_eq("to_enter", 32'(state), 32'd1);
        check_eq("to_lost_clr", 32'(link_lost), 32'd0);
        repeat (99) cycle();
        check_eq("to_still", 32'(state), 32'd1);
        cycle();
        check_eq("to_state", 32'(state), TIMEOUT_EN ? 32'd0 : 32'd1);
        check_eq("to_lost", 32'(link_lost), TIMEOUT_EN ? 32'd1 : 32'd0);
        pulse_return();
        pulse_connect();
        check_eq("to_reconnect_clr", 32'(link_lost), 32'd0);
        pulse_return();

        // Asynchronous reset in the middle of GAME
        rx_connect = 2'b11;
        repeat (3) cycle();
        pulse_connect();
        cycle();
        pulse_start();
        cycle();
        check_eq("rst_pre_game", 32'(state), 32'd3);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_async", 32'(dut_vec()), 32'd0);
        model_reset();
        cycle(); cycle();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_eq("rst_no_init", 32'(game_init), 32'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            connect_req  = ($urandom_range(0, 7) == 0);
            start_req    = ($urandom_range(0, 15) == 0);
            return_req   = ($urandom_range(0, 40) == 0);
            local_finish = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 29) == 0)
                rx_connect = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            rx_start  = ($urandom_range(0, 12) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rx_finish = ($urandom_range(0, 25) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
